// File: rtl/up_sequencer.sv
// up_sequencer: Moore controller that multiplies R = M * Q (mod 16) on the uPHardware datapath by repeated addition.
// Optional macro WATCHDOG_EN: caps the add loop at MAX_ITER passes and traps in a sticky error state.
module up_sequencer #(
  parameter int unsigned MAX_ITER = 15,
  parameter int unsigned CW       = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ack,
  input  logic          Z,
  output logic [CW-1:0] Control,
  output logic          in_sel,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    StIdle,
    StLdm,
    StLdq,
    StTest,
    StAdd,
    StAcc,
    StDone,
    StErr
  } state_t;

  // Control words: [0] OutBus, [1] ld M, [2] clr R, [3] add, [4] dec Q, [5] ld R, [6] ld Q
  localparam logic [CW-1:0] CtrlNone = 7'b0000000;
  localparam logic [CW-1:0] CtrlLdm  = 7'b0000010;
  localparam logic [CW-1:0] CtrlLdq  = 7'b1000100;
  localparam logic [CW-1:0] CtrlAdd  = 7'b0011000;
  localparam logic [CW-1:0] CtrlAcc  = 7'b0100000;
  localparam logic [CW-1:0] CtrlDone = 7'b0000001;

  state_t        r_state;
  state_t        w_nxt;
  logic [CW-1:0] w_ctrl;
  logic [CW-1:0] r_control;
  logic          r_in_sel;
  logic          r_busy;
  logic          r_done;

`ifdef WATCHDOG_EN
  localparam logic [3:0] IterMax = 4'(MAX_ITER);
  logic [3:0] r_iter;
  logic       r_err;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      StIdle: if (start) w_nxt = StLdm;
      StLdm:  w_nxt = StLdq;
      StLdq:  w_nxt = StTest;
      StTest: begin
        if (Z) w_nxt = StAdd;
        else   w_nxt = StDone;
`ifdef WATCHDOG_EN
        if (Z && (r_iter == IterMax)) w_nxt = StErr;
`endif
      end
      StAdd:  w_nxt = StAcc;
      StAcc:  w_nxt = StTest;
      StDone: if (ack) w_nxt = StIdle;
      StErr:  w_nxt = StErr;
      default: w_nxt = StIdle;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as r_state.
  always_comb begin
    w_ctrl = CtrlNone;
    case (w_nxt)
      StLdm:   w_ctrl = CtrlLdm;
      StLdq:   w_ctrl = CtrlLdq;
      StAdd:   w_ctrl = CtrlAdd;
      StAcc:   w_ctrl = CtrlAcc;
      StDone:  w_ctrl = CtrlDone;
      default: w_ctrl = CtrlNone;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_control <= '0;
      r_in_sel  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_control <= w_ctrl;
      r_in_sel  <= (w_nxt == StLdq);
      r_busy    <= (w_nxt != StIdle);
      r_done    <= (w_nxt == StDone);
    end
  end

`ifdef WATCHDOG_EN
  // Counts ADD entries since the operands were loaded; a legal Q=15 reaches the bound with Z=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter <= 4'd0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == StLdq) begin
        r_iter <= 4'd0;
      end else if ((w_nxt == StAdd) && (r_state != StAdd)) begin
        r_iter <= r_iter + 4'd1;
      end
      r_err <= (w_nxt == StErr);
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign Control = r_control;
  assign in_sel  = r_in_sel;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_up_sequencer.sv
// Bench for up_sequencer: drives a small behavioural datapath and checks results/latency against M*Q mod 16.
`timescale 1ns/1ps
module tb_up_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ack;
  logic       Z;
  logic [6:0] Control;
  logic       in_sel;
  logic       busy;
  logic       done;
  logic       err;

  logic [3:0] op_m, op_q;
  logic [3:0] dp_m, dp_q, dp_r, dp_aout;
  logic [3:0] in_bus;
  logic       z_force;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [6:0] CLdm  = 7'b0000010;
  localparam logic [6:0] CLdq  = 7'b1000100;
  localparam logic [6:0] CTest = 7'b0000000;
  localparam logic [6:0] CAdd  = 7'b0011000;
  localparam logic [6:0] CAcc  = 7'b0100000;
  localparam logic [6:0] CDone = 7'b0000001;

  always #5 clk = ~clk;

  up_sequencer #(.MAX_ITER(15), .CW(7)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ack    (ack),
    .Z      (Z),
    .Control(Control),
    .in_sel (in_sel),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  // Environment: operand mux onto InBus and the uPHardware datapath registers.
  assign in_bus = in_sel ? op_q : op_m;
  assign Z      = z_force | (dp_q != 4'd0);

  always_ff @(posedge clk) begin
    if (Control[1]) dp_m <= in_bus;
    if (Control[6]) dp_q <= in_bus;
    else if (Control[4]) dp_q <= dp_q - 4'd1;
    if (Control[2]) dp_r <= 4'd0;
    else if (Control[5]) dp_r <= dp_aout;
    if (Control[3]) dp_aout <= dp_r + dp_m;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("ctrl_exclusive", int'(!(Control[0] && (|Control[6:1])) && !(Control[1] && Control[6])), 1);
  endtask

  // One multiply transaction; returns OutBus result and start-to-done edge count.
  task automatic run_op(input logic [3:0] m, input logic [3:0] q, input int ack_dly,
                        input bit start_in_done, input bit noise,
                        output logic [3:0] res, output int lat);
    logic [6:0] seq[$];
    logic [6:0] exp_seq[$];
    op_m = m;
    op_q = q;
    start = 1'b1;
    tick();
    start = 1'b0;
    seq.push_back(Control);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (noise && k == 1) ack = 1'b1;
      if (noise && k == 2) start = 1'b1;
      tick();
      ack = 1'b0;
      start = 1'b0;
      seq.push_back(Control);
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
    res = Control[0] ? dp_r : 4'hx;
    exp_seq.push_back(CLdm);
    exp_seq.push_back(CLdq);
    exp_seq.push_back(CTest);
    for (int i = 0; i < int'(q); i++) begin
      exp_seq.push_back(CAdd);
      exp_seq.push_back(CAcc);
      exp_seq.push_back(CTest);
    end
    exp_seq.push_back(CDone);
    check("ctrl_seq_len", seq.size(), exp_seq.size());
    for (int i = 0; i < seq.size() && i < exp_seq.size(); i++)
      check($sformatf("ctrl_seq[%0d]", i), int'(seq[i]), int'(exp_seq[i]));
    for (int d = 0; d < ack_dly; d++) begin
      tick();
      check("done_held", int'(done), 1);
      check("ctrl_held", int'(Control), int'(CDone));
    end
    ack = 1'b1;
    start = start_in_done;
    tick();
    ack = 1'b0;
    start = 1'b0;
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    check("idle_ctrl", int'(Control), 0);
    tick();
    check("idle_stays", int'(busy), 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctrl", int'(Control), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_sel", int'(in_sel), 0);
    check("rst_err", int'(err), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [3:0] exp_r;
    int         exp_lat;
    int         ack_dly;
  } vec_t;

  initial begin
    vec_t       vecs[7];
    logic [3:0] res;
    int         lat;
    int         adds;
    bit         found;
    bit         err_seen;

    rst_n = 1'b1; start = 1'b0; ack = 1'b0; z_force = 1'b0; op_m = 4'd0; op_q = 4'd0;
    do_reset();

    vecs[0] = '{m: 4'd3,  q: 4'd5,  exp_r: 4'd15, exp_lat: 18, ack_dly: 0};
    vecs[1] = '{m: 4'd9,  q: 4'd0,  exp_r: 4'd0,  exp_lat: 3,  ack_dly: 1};
    vecs[2] = '{m: 4'd7,  q: 4'd3,  exp_r: 4'd5,  exp_lat: 12, ack_dly: 0};
    vecs[3] = '{m: 4'd2,  q: 4'd2,  exp_r: 4'd4,  exp_lat: 9,  ack_dly: 2};
    vecs[4] = '{m: 4'd15, q: 4'd15, exp_r: 4'd1,  exp_lat: 48, ack_dly: 0};
    vecs[5] = '{m: 4'd0,  q: 4'd7,  exp_r: 4'd0,  exp_lat: 24, ack_dly: 1};
    vecs[6] = '{m: 4'd4,  q: 4'd4,  exp_r: 4'd0,  exp_lat: 15, ack_dly: 0};
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].m, vecs[i].q, vecs[i].ack_dly, 1'b0, 1'b0, res, lat);
      check($sformatf("vec%0d_result", i), int'(res), int'(vecs[i].exp_r));
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
    end

    // Reset asserted in the middle of an ADD state, then a fresh 2*2.
    op_m = 4'd5; op_q = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (Control == CAdd) found = 1'b1;
    end
    check("reached_add", int'(found), 1);
    do_reset();
    run_op(4'd2, 4'd2, 0, 1'b0, 1'b0, res, lat);
    check("post_rst_result", int'(res), 4);
    check("post_rst_latency", lat, 9);

    // Stray start/ack while busy, ack delayed 3 cycles, then start+ack together in DONE.
    run_op(4'd3, 4'd2, 3, 1'b0, 1'b1, res, lat);
    check("busy_start_result", int'(res), 6);
    check("busy_start_latency", lat, 9);
    run_op(4'd5, 4'd1, 0, 1'b1, 1'b0, res, lat);
    check("start_ack_result", int'(res), 5);

    // Randomized operands against the arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      logic [3:0] m, q;
      int exp_r;
      m = 4'($urandom_range(15));
      q = 4'($urandom_range(15));
      exp_r = (int'(m) * int'(q)) % 16;
      run_op(m, q, int'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
             res, lat);
      check($sformatf("rnd%0d_result", i), int'(res), exp_r);
      check($sformatf("rnd%0d_latency", i), lat, 3 + 3 * int'(q));
    end

    // Stuck Z=1: watchdog trap when enabled, endless loop otherwise.
    z_force = 1'b1;
    op_m = 4'd1; op_q = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    adds = 0;
    err_seen = 1'b0;
`ifdef WATCHDOG_EN
    for (int k = 0; k < 80 && !err_seen; k++) begin
      tick();
      if (Control == CAdd) adds++;
      if (err) err_seen = 1'b1;
    end
    check("wd_err", int'(err_seen), 1);
    check("wd_adds", adds, 15);
    check("wd_ctrl", int'(Control), 0);
    check("wd_busy", int'(busy), 1);
    check("wd_done", int'(done), 0);
    z_force = 1'b0;
    repeat (5) tick();
    check("wd_err_sticky", int'(err), 1);
`else
    for (int k = 0; k < 60; k++) begin
      tick();
      if (Control == CAdd) adds++;
      if (err) err_seen = 1'b1;
    end
    check("nowd_err", int'(err_seen), 0);
    check("nowd_looping", int'(adds > 15), 1);
    check("nowd_busy", int'(busy), 1);
    z_force = 1'b0;
`endif
    do_reset();
    run_op(4'd6, 4'd3, 0, 1'b0, 1'b0, res, lat);
    check("final_result", int'(res), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
